// File: rtl/systick_alarm_pkg.sv
// Shared peripheral-bus and alarm definitions used by systick_alarm and peer blocks.
// Latency: none (constants and types only).
// Backpressure: none; the bus is a single-cycle mode/addr/data handshake.
package systick_alarm_pkg;

    // Bus mode encodings
    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;

    // Register byte offsets from the block base address
    localparam logic [31:0] ALARM_CTRL   = 32'h0;
    localparam logic [31:0] ALARM_RELOAD = 32'h4;
    localparam logic [31:0] ALARM_COUNT  = 32'h8;
    localparam logic [31:0] ALARM_STATUS = 32'hC;

    // CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_PER    = 1;
    localparam int CTRL_IRQ_EN = 2;

    // Countdown FSM state
    typedef logic [0:0] alarm_state_t;
    localparam alarm_state_t ST_IDLE = 1'b0;
    localparam alarm_state_t ST_RUN  = 1'b1;

    // One write strobe per register
    typedef struct packed {
        logic ctrl;
        logic reload;
        logic count;
        logic status;
    } reg_sel_t;

endpackage

// File: rtl/systick_alarm_periph_bus_port.sv
// Peripheral bus slave port: decodes the four register words, muxes read data, strobes writes.
// Latency: reads are combinational; write strobes are combinational and sampled by the owner.
// Backpressure: none; the bus is driven only on a matching read, otherwise left high-impedance.
module periph_bus_port
    import systick_alarm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4020
)
(
    inout  wire  [31:0] io_bus_data,
    input  logic [31:0] i_bus_addr,
    input  logic [1:0]  i_bus_mode,
    input  logic [31:0] i_ctrl_dat,
    input  logic [31:0] i_reload_dat,
    input  logic [31:0] i_count_dat,
    input  logic [31:0] i_status_dat,
    output reg_sel_t    o_wr_sel,
    output logic [31:0] o_wr_dat
);

    reg_sel_t    w_sel;
    logic        w_hit;
    logic [31:0] w_rd_dat;

    // Exact word-address decode of the four registers
    always_comb begin
        w_sel        = '0;
        w_sel.ctrl   = (i_bus_addr == BASE_ADDR + ALARM_CTRL);
        w_sel.reload = (i_bus_addr == BASE_ADDR + ALARM_RELOAD);
        w_sel.count  = (i_bus_addr == BASE_ADDR + ALARM_COUNT);
        w_sel.status = (i_bus_addr == BASE_ADDR + ALARM_STATUS);
    end

    assign w_hit = |w_sel;

    // Read data mux; selects are one-hot so priority order is irrelevant
    always_comb begin
        w_rd_dat = '0;
        if (w_sel.ctrl)   w_rd_dat = i_ctrl_dat;
        if (w_sel.reload) w_rd_dat = i_reload_dat;
        if (w_sel.count)  w_rd_dat = i_count_dat;
        if (w_sel.status) w_rd_dat = i_status_dat;
    end

    assign io_bus_data = ((i_bus_mode == MODE_READ) && w_hit) ? w_rd_dat : 'z;
    assign o_wr_sel    = (i_bus_mode == MODE_WRITE) ? w_sel : '0;
    assign o_wr_dat    = io_bus_data;

endmodule

// File: rtl/systick_alarm.sv
// Bus-mapped millisecond countdown alarm with one-shot/periodic modes and a level irq.
// Latency: writes visible next cycle; expired sets on the tick edge, irq follows one cycle later.
// Backpressure: none; ticks arriving on a CTRL-write edge or while idle are dropped.
module systick_alarm
    import systick_alarm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4020
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_pulse,
    inout  wire  [31:0] data_bus_data,
    input  logic [31:0] data_bus_addr,
    input  logic [1:0]  data_bus_mode,
    output logic        irq
);

    reg_sel_t     w_wr_sel;
    logic [31:0]  w_wr_dat;
    logic [31:0]  w_ctrl_dat;
    logic [31:0]  w_status_dat;
    logic         w_start;
    logic         w_count_tick;
    logic         w_expire;
    logic         w_clear;

    alarm_state_t r_state;
    logic         r_enable;
    logic         r_periodic;
    logic         r_irq_en;
    logic [31:0]  r_reload;
    logic [31:0]  r_count;
    logic         r_expired;
    logic         r_irq;

    assign w_ctrl_dat   = {29'd0, r_irq_en, r_periodic, r_enable};
    assign w_status_dat = {31'd0, r_expired};

    periph_bus_port #(
        .BASE_ADDR (BASE_ADDR)
    ) u_bus_port (
        .io_bus_data  (data_bus_data),
        .i_bus_addr   (data_bus_addr),
        .i_bus_mode   (data_bus_mode),
        .i_ctrl_dat   (w_ctrl_dat),
        .i_reload_dat (r_reload),
        .i_count_dat  (r_count),
        .i_status_dat (w_status_dat),
        .o_wr_sel     (w_wr_sel),
        .o_wr_dat     (w_wr_dat)
    );

    // A CTRL write owns the edge: any tick on it is discarded
    assign w_start      = w_wr_sel.ctrl && w_wr_dat[CTRL_EN] && (r_reload != 32'd0);
    assign w_count_tick = !w_wr_sel.ctrl && (r_state == ST_RUN) && tick_pulse;
    assign w_expire     = w_count_tick && (r_count <= 32'd1);
    assign w_clear      = w_wr_sel.status && w_wr_dat[0];

    // Control register, FSM and countdown
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_enable   <= 1'b0;
            r_periodic <= 1'b0;
            r_irq_en   <= 1'b0;
            r_count    <= 32'd0;
        end else if (w_wr_sel.ctrl) begin
            r_periodic <= w_wr_dat[CTRL_PER];
            r_irq_en   <= w_wr_dat[CTRL_IRQ_EN];
            if (w_start) begin
                r_enable <= 1'b1;
                r_state  <= ST_RUN;
                r_count  <= r_reload;
            end else begin
                // Stop (or refused start with RELOAD==0); COUNT is left as-is
                r_enable <= 1'b0;
                r_state  <= ST_IDLE;
            end
        end else if (w_count_tick) begin
            if (r_count > 32'd1) begin
                r_count <= r_count - 32'd1;
            end else if (r_periodic) begin
                r_count <= r_reload;
            end else begin
                r_count  <= 32'd0;
                r_state  <= ST_IDLE;
                r_enable <= 1'b0;
            end
        end
    end

    // RELOAD is only sampled into COUNT on start/restart/periodic reload
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_reload <= 32'd0;
        end else if (w_wr_sel.reload) begin
            r_reload <= w_wr_dat;
        end
    end

    // Sticky expired flag; a same-edge expiry beats the W1C clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_expired <= 1'b0;
        end else if (w_expire) begin
            r_expired <= 1'b1;
        end else if (w_clear) begin
            r_expired <= 1'b0;
        end
    end

    // Registered interrupt, one cycle behind STATUS/irq_en
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_expired & r_irq_en;
        end
    end

    assign irq = r_irq;

endmodule

// File: tb/tb_systick_alarm.sv
// Directed bench for systick_alarm with a queue-based scoreboard.
// Stimulus pushes expected bus/irq values; the monitor pops and compares on the falling edge.
// Bus 'z' is accepted as either high-impedance or an undriven 2-state zero.
module tb_systick_alarm;

    localparam logic [31:0] A_CTRL   = 32'h4020;
    localparam logic [31:0] A_RELOAD = 32'h4024;
    localparam logic [31:0] A_COUNT  = 32'h4028;
    localparam logic [31:0] A_STATUS = 32'h402C;
    localparam logic [31:0] A_UNMAP  = 32'h4030;

    localparam int K_BUS = 0;
    localparam int K_IRQ = 1;
    localparam int K_Z   = 2;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        int          id;
    } sb_t;

    logic        clk;
    logic        reset;
    logic        tick_pulse;
    logic [31:0] bus_addr;
    logic [1:0]  bus_mode;
    logic [31:0] tb_dat;
    logic        tb_en;
    logic        irq;
    wire  [31:0] data_bus_data;

    logic        chk_vld;
    sb_t         sb_q[$];
    int          step;
    int          n_chk;
    int          n_fail;

    assign data_bus_data = tb_en ? tb_dat : 'z;

    systick_alarm dut (
        .clk           (clk),
        .reset         (reset),
        .tick_pulse    (tick_pulse),
        .data_bus_data (data_bus_data),
        .data_bus_addr (bus_addr),
        .data_bus_mode (bus_mode),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: consume every expectation queued for this observation cycle
    always @(negedge clk) begin
        if (chk_vld) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sample_without_expectation at %0t", $time);
            end
            while (sb_q.size() > 0) begin
                sb_t e;
                e = sb_q.pop_front();
                n_chk++;
                case (e.kind)
                    K_BUS: if (data_bus_data !== e.exp) begin
                        n_fail++;
                        $display("FAIL chk%0d bus_read addr=%h got %h expected %h", e.id, bus_addr, data_bus_data, e.exp);
                    end
                    K_IRQ: if (irq !== e.exp[0]) begin
                        n_fail++;
                        $display("FAIL chk%0d irq got %b expected %b", e.id, irq, e.exp[0]);
                    end
                    default: if (!((data_bus_data === 32'hzzzz_zzzz) || (data_bus_data === 32'h0))) begin
                        n_fail++;
                        $display("FAIL chk%0d bus_undriven mode=%b addr=%h got %h expected z", e.id, bus_mode, bus_addr, data_bus_data);
                    end
                endcase
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [31:0] v);
        sb_t e;
        e.kind = kind;
        e.exp  = v;
        e.id   = step;
        step++;
        sb_q.push_back(e);
    endtask

    task automatic exp_rd(input logic [31:0] a, input logic [31:0] v);
        bus_mode = 2'b01;
        bus_addr = a;
        push(K_BUS, v);
    endtask

    task automatic exp_z(input logic [1:0] m, input logic [31:0] a);
        bus_mode = m;
        bus_addr = a;
        push(K_Z, 32'h0);
    endtask

    task automatic exp_irq(input logic v);
        push(K_IRQ, {31'd0, v});
    endtask

    task automatic sample();
        chk_vld = 1'b1;
        cyc();
        chk_vld  = 1'b0;
        bus_mode = 2'b00;
    endtask

    task automatic chk_rd(input logic [31:0] a, input logic [31:0] v);
        exp_rd(a, v);
        sample();
    endtask

    task automatic chk_irq(input logic v);
        exp_irq(v);
        sample();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic tk);
        bus_mode   = 2'b10;
        bus_addr   = a;
        tb_dat     = d;
        tb_en      = 1'b1;
        tick_pulse = tk;
        cyc();
        bus_mode   = 2'b00;
        tb_en      = 1'b0;
        tick_pulse = 1'b0;
    endtask

    task automatic tick();
        tick_pulse = 1'b1;
        cyc();
        tick_pulse = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        tick_pulse = 1'b0;
        bus_addr   = 32'h0;
        bus_mode   = 2'b00;
        tb_dat     = 32'h0;
        tb_en      = 1'b0;
        chk_vld    = 1'b0;
        step       = 0;
        n_chk      = 0;
        n_fail     = 0;
        repeat (3) cyc();
        reset = 1'b1;
        cyc();

        // 1. Reset state, read-only COUNT, undriven bus cases
        exp_rd(A_CTRL, 32'h0); exp_irq(1'b0); sample();
        chk_rd(A_RELOAD, 32'h0);
        chk_rd(A_COUNT, 32'h0);
        chk_rd(A_STATUS, 32'h0);
        exp_z(2'b00, A_CTRL); sample();
        wr(A_COUNT, 32'd7, 1'b0);
        chk_rd(A_COUNT, 32'h0);

        // 2. One-shot RELOAD=3, irq enabled
        wr(A_RELOAD, 32'd3, 1'b0);
        wr(A_CTRL, 32'h5, 1'b0);
        chk_rd(A_COUNT, 32'd3);
        exp_z(2'b00, A_RELOAD); sample();
        exp_z(2'b11, A_RELOAD); sample();
        exp_z(2'b01, A_UNMAP); sample();
        tick();
        chk_rd(A_COUNT, 32'd2);
        tick();
        chk_rd(A_COUNT, 32'd1);
        tick();
        exp_rd(A_STATUS, 32'd1); exp_irq(1'b0); sample();
        exp_rd(A_COUNT, 32'd0);  exp_irq(1'b1); sample();
        chk_rd(A_CTRL, 32'h4);
        tick();
        chk_rd(A_COUNT, 32'd0);
        wr(A_STATUS, 32'h0, 1'b0);
        chk_rd(A_STATUS, 32'd1);
        wr(A_STATUS, 32'h1, 1'b0);
        exp_rd(A_STATUS, 32'd0); exp_irq(1'b1); sample();
        chk_irq(1'b0);

        // 3. Periodic RELOAD=2, irq disabled, expiries after ticks 2/4/6
        wr(A_RELOAD, 32'd2, 1'b0);
        wr(A_CTRL, 32'h3, 1'b0);
        chk_rd(A_COUNT, 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_rd(A_COUNT, 32'd1); sample();
            chk_rd(A_STATUS, 32'd0);
            tick();
            exp_rd(A_STATUS, 32'd1); exp_irq(1'b0); sample();
            chk_rd(A_COUNT, 32'd2);
            if (i < 2) wr(A_STATUS, 32'h1, 1'b0);
        end

        // 4. W1C colliding with an expiry: set wins
        wr(A_CTRL, 32'h7, 1'b0);
        exp_rd(A_COUNT, 32'd2); exp_irq(1'b0); sample();
        chk_irq(1'b1);
        tick();
        chk_rd(A_COUNT, 32'd1);
        wr(A_STATUS, 32'h1, 1'b1);
        exp_rd(A_STATUS, 32'd1); exp_irq(1'b1); sample();
        exp_rd(A_COUNT, 32'd2);  exp_irq(1'b1); sample();
        wr(A_STATUS, 32'h1, 1'b0);
        exp_rd(A_STATUS, 32'd0); exp_irq(1'b1); sample();
        chk_irq(1'b0);

        // 5. RELOAD deferred in RUN, CTRL write beats tick, stop holds COUNT, RELOAD=0 start refused
        wr(A_RELOAD, 32'd5, 1'b0);
        chk_rd(A_COUNT, 32'd2);
        wr(A_CTRL, 32'h7, 1'b1);
        chk_rd(A_COUNT, 32'd5);
        tick();
        chk_rd(A_COUNT, 32'd4);
        wr(A_CTRL, 32'h0, 1'b0);
        tick();
        chk_rd(A_COUNT, 32'd4);
        wr(A_RELOAD, 32'd0, 1'b0);
        wr(A_CTRL, 32'h5, 1'b0);
        exp_rd(A_CTRL, 32'h4); exp_irq(1'b0); sample();
        tick();
        tick();
        exp_rd(A_COUNT, 32'd4); exp_irq(1'b0); sample();
        chk_rd(A_STATUS, 32'd0);

        // 6. Reset asserted mid-count aborts with no irq
        wr(A_RELOAD, 32'd5, 1'b0);
        wr(A_CTRL, 32'h5, 1'b0);
        chk_rd(A_COUNT, 32'd5);
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        exp_rd(A_COUNT, 32'd0); exp_irq(1'b0); sample();
        chk_rd(A_CTRL, 32'h0);
        chk_rd(A_RELOAD, 32'h0);
        repeat (3) tick();
        exp_rd(A_COUNT, 32'd0); exp_irq(1'b0); sample();
        chk_rd(A_STATUS, 32'd0);

        cyc();
        if (sb_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain left %0d expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
